// File: rtl/up_down_count_scheduler_pkg.sv
// Shared types for the up/down count scheduler: FSM state encoding and
// direction constants.
package udc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } udc_state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/up_down_count_scheduler_core.sv
// Mod-N up/down counter. When en is high, q steps one position in direction
// dir, and wrap is registered together with any q update that wraps.
module udc_core
  import udc_pkg::*;
#(
  parameter int N = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 dir,
  output logic [$clog2(N)-1:0] q,
  output logic                 wrap
);

  localparam int QW = $clog2(N);
  localparam logic [QW-1:0] Q_MAX = QW'(N - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= '0;
      wrap <= 1'b0;
    end else if (en) begin
      if (dir == DIR_UP) begin
        if (q == Q_MAX) begin
          q    <= '0;
          wrap <= 1'b1;
        end else begin
          q    <= q + QW'(1);
          wrap <= 1'b0;
        end
      end else begin
        if (q == '0) begin
          q    <= Q_MAX;
          wrap <= 1'b1;
        end else begin
          q    <= q - QW'(1);
          wrap <= 1'b0;
        end
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: rtl/up_down_count_scheduler.sv
// Command sequencer that drives udc_core one step per RUN cycle. Optional
// macro UDC_SCHED_PAUSE_EN adds a pause input that freezes a run in progress.
module up_down_count_scheduler
  import udc_pkg::*;
#(
  parameter int N      = 10,
  parameter int STEP_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_dir,
  input  logic [STEP_W-1:0]    cmd_steps,
  input  logic                 abort,
`ifdef UDC_SCHED_PAUSE_EN
  input  logic                 pause,
`endif
  output logic [$clog2(N)-1:0] q,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic                 wrap,
  output udc_state_e           state_dbg
);

  // Handshake: a command transfers on any rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready is high only in IDLE, and a command
  // left valid while cmd_ready is low simply waits.

  udc_state_e        state, state_nx;
  logic [STEP_W-1:0] remaining;
  logic              dir_r;
  logic              aborted_r;
  logic              step_en;
  logic              run_hold;

`ifdef UDC_SCHED_PAUSE_EN
  assign run_hold = pause;
`else
  assign run_hold = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    step_en  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) state_nx = (cmd_steps != '0) ? RUN : DONE;
      end
      RUN: begin
        // Abort outranks both pause and the final step.
        if (abort) begin
          state_nx = DONE;
        end else if (!run_hold) begin
          step_en = 1'b1;
          if (remaining == STEP_W'(1)) state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      dir_r     <= DIR_UP;
      aborted_r <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && cmd_valid) begin
        dir_r     <= cmd_dir;
        remaining <= cmd_steps;
        aborted_r <= 1'b0;
      end else if (state == RUN && abort) begin
        aborted_r <= 1'b1;
      end else if (step_en) begin
        remaining <= remaining - STEP_W'(1);
      end
    end
  end

  udc_core #(.N(N)) u_core (
    .clk  (clk),
    .rst  (rst),
    .en   (step_en),
    .dir  (dir_r),
    .q    (q),
    .wrap (wrap)
  );

  assign cmd_ready = (state == IDLE);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign aborted   = (state == DONE) && aborted_r;
  assign state_dbg = state;

endmodule

// File: tb/tb_up_down_count_scheduler.sv
// Directed bench for up_down_count_scheduler (N=10, STEP_W=8) with
// hand-computed expected values and immediate-assertion checks.
module tb_up_down_count_scheduler;
  import udc_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_dir = 1'b0;
  logic [7:0] cmd_steps = 8'd0;
  logic       abort = 1'b0;
`ifdef UDC_SCHED_PAUSE_EN
  logic       pause = 1'b0;
`endif
  logic [3:0] q;
  logic       busy, done, aborted, wrap;
  udc_state_e state_dbg;

  int tests = 0;
  int failures = 0;

  always #5 clk = ~clk;

  up_down_count_scheduler #(.N(10), .STEP_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_steps (cmd_steps),
    .abort     (abort),
`ifdef UDC_SCHED_PAUSE_EN
    .pause     (pause),
`endif
    .q         (q),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .wrap      (wrap),
    .state_dbg (state_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command and consume its accept edge.
  task automatic issue(input logic dir, input logic [7:0] steps);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_steps = steps;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic chk_done(input string tag, input logic [31:0] exp_q, input logic exp_ab);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_aborted"}, aborted, exp_ab);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_q_hold"}, q, exp_q);
    step();
    chk({tag, "_idle_ready"}, cmd_ready, 1'b1);
    chk({tag, "_done_clr"}, done, 1'b0);
  endtask

  initial begin
    int up5_q[5]    = '{1, 2, 3, 4, 5};
    int upw_q[4]    = '{9, 0, 1, 2};
    int upw_w[4]    = '{0, 1, 0, 0};
    int dnw_q[3]    = '{0, 9, 8};
    int dnw_w[3]    = '{0, 1, 0};

    // Reset state
    #2;
    chk("rst_q", q, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wrap", wrap, 0);
    step();
    #2 rst = 1'b0;

    // Abort while idle is ignored
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("idle_abort_ready", cmd_ready, 1);
    chk("idle_abort_done", done, 0);

    // Up 5 from 0
    issue(DIR_UP, 8'd5);
    chk("up5_accept_q", q, 0);
    chk("up5_accept_busy", busy, 1);
    chk("up5_accept_ready", cmd_ready, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("up5_q%0d", i), q, up5_q[i]);
      chk($sformatf("up5_wrap%0d", i), wrap, 0);
    end
    chk_done("up5", 5, 1'b0);

    // Move to 8, then up 4 across the wrap
    issue(DIR_UP, 8'd3);
    for (int i = 0; i < 3; i++) step();
    chk("to8_q", q, 8);
    step();
    issue(DIR_UP, 8'd4);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("upw_q%0d", i), q, upw_q[i]);
      chk($sformatf("upw_wrap%0d", i), wrap, upw_w[i]);
    end
    chk_done("upw", 2, 1'b0);

    // Move to 1, then down 3 across the wrap
    issue(DIR_DOWN, 8'd1);
    step();
    chk("to1_q", q, 1);
    step();
    issue(DIR_DOWN, 8'd3);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("dnw_q%0d", i), q, dnw_q[i]);
      chk($sformatf("dnw_wrap%0d", i), wrap, dnw_w[i]);
    end
    chk_done("dnw", 8, 1'b0);

    // Zero-step command: straight to DONE, q unchanged
    issue(DIR_UP, 8'd0);
    chk("zero_wrap", wrap, 0);
    chk_done("zero", 8, 1'b0);

    // Back to 0, then up 20 aborted at q=6
    issue(DIR_UP, 8'd2);
    step();
    step();
    chk("to0_q", q, 0);
    step();
    issue(DIR_UP, 8'd20);
    for (int i = 0; i < 6; i++) step();
    chk("abort_pre_q", q, 6);
    abort = 1'b1;
    step();
    abort = 1'b0;
    // Next command held valid during DONE; accepted on the following edge.
    cmd_valid = 1'b1;
    cmd_dir   = DIR_UP;
    cmd_steps = 8'd7;
    chk("abort_ready_low", cmd_ready, 0);
    chk_done("abort", 6, 1'b1);
    step();
    cmd_valid = 1'b0;
    chk("held_accept_busy", busy, 1);
    chk("held_accept_q", q, 6);

    // Async reset in the middle of the up-7 run
    step();
    step();
    chk("up7_q", q, 8);
    #3 rst = 1'b1;
    #1;
    chk("arst_q", q, 0);
    chk("arst_ready", cmd_ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    step();
    #2 rst = 1'b0;
    step();
    chk("post_rst_done", done, 0);

    // Down 2 after reset release
    issue(DIR_DOWN, 8'd2);
    step();
    chk("dn2_q0", q, 9);
    chk("dn2_wrap0", wrap, 1);
    step();
    chk("dn2_q1", q, 8);
    chk("dn2_wrap1", wrap, 0);
    chk_done("dn2", 8, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
